rca4_registered_adder: RTL and testbench



---
 rtl/rca4_registered_adder_if.sv | 12 +
 rtl/rca4_registered_adder.sv | 71 +++++++
 tb/tb_rca4_registered_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rca4_registered_adder_if.sv
// Operand/result bundle for the registered 4-bit adder.
// The master drives A/B/cin and observes sum/cout; the slave is the adder itself.
interface rca4_registered_adder_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    modport master (output A, output B, output cin, input sum, input cout);
    modport slave  (input A, input B, input cin, output sum, output cout);
endinterface

// File: rtl/rca4_registered_adder.sv
// Registered 4-bit ripple-carry adder built structurally from half adders and full adders.
// No handshake: the output register loads A + B + cin on every non-reset rising edge.

module rca4_half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// Leaf cell with standalone-testable ports: sum = A^B^cin, cout = AB | cin(A^B).
module rca4_full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic p;
    logic g;
    logic pc;

    rca4_half_adder u_ha0 (.a(A), .b(B),   .s(p),   .c(g));
    rca4_half_adder u_ha1 (.a(p), .b(cin), .s(sum), .c(pc));

    assign cout = g | pc;
endmodule

module rca4_registered_adder (
    input logic                  clk,
    input logic                  rst,
    rca4_registered_adder_if.slave bus
);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [4:0] c;
    logic [3:0] sum_q;
    logic       cout_q;

    assign a    = bus.A;
    assign b    = bus.B;
    assign c[0] = bus.cin;

    // Carry of stage i feeds stage i+1; c[4] is the carry out of bit 3.
    for (genvar i = 0; i < 4; i++) begin : g_chain
        rca4_full_adder u_fa (
            .A    (a[i]),
            .B    (b[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= s;
            cout_q <= c[4];
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_rca4_registered_adder.sv
// Self-checking bench: full-adder leaf sweep, directed vector table, reset/latency
// sequences and an exhaustive 512-combination sweep against an arithmetic model.
module tb_rca4_registered_adder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rca4_registered_adder_if bus ();

    rca4_registered_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic fa_a;
    logic fa_b;
    logic fa_cin;
    logic fa_sum;
    logic fa_cout;

    rca4_full_adder u_leaf (
        .A    (fa_a),
        .B    (fa_b),
        .cin  (fa_cin),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];
    logic [4:0] exp_q[$];

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got cout/sum=%b_%b expected %b_%b",
                     name, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    // driver: present operands, then advance one rising edge and settle
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        bus.A   = a;
        bus.B   = b;
        bus.cin = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] got;
        logic [4:0] exp;
        logic       ea;
        logic       eb;
        logic       ec;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        drive(4'd0, 4'd0, 1'b0);
        fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0;

        vecs[0] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vecs[1] = '{4'b0000, 4'b1000, 1'b0, 4'b1000, 1'b0};
        vecs[2] = '{4'd15,   4'd15,   1'b1, 4'd15,   1'b1};
        vecs[3] = '{4'd3,    4'd4,    1'b0, 4'd7,    1'b0};
        vecs[4] = '{4'd9,    4'd8,    1'b1, 4'd2,    1'b1};
        vecs[5] = '{4'd5,    4'd10,   1'b0, 4'd15,   1'b0};
        vecs[6] = '{4'd0,    4'd0,    1'b0, 4'd0,    1'b0};
        vecs[7] = '{4'd7,    4'd9,    1'b0, 4'd0,    1'b1};

        // Full-adder leaf, exhaustive with A toggling fastest
        for (int i = 0; i < 8; i++) begin
            ea = i[0]; eb = i[1]; ec = i[2];
            fa_a = ea; fa_b = eb; fa_cin = ec;
            #1;
            exp = {3'b000, (ea & eb) | (ea & ec) | (eb & ec), ea ^ eb ^ ec};
            check($sformatf("leaf_%0d", i), {3'b000, fa_cout, fa_sum}, exp);
        end

        // Reset state
        step();
        check("reset_state", {bus.cout, bus.sum}, 5'b0_0000);

        // Directed vector table
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            step();
            check($sformatf("vec_%0d", i), {bus.cout, bus.sum}, {vecs[i].exp_cout, vecs[i].exp_sum});
        end

        // Reset mid-operation discards the addition, then a fresh load follows
        drive(4'b1111, 4'b1111, 1'b1);
        rst = 1'b1;
        step();
        check("reset_discard", {bus.cout, bus.sum}, 5'b0_0000);
        rst = 1'b0;
        step();
        check("reset_release", {bus.cout, bus.sum}, 5'b1_1111);

        // Latency: output holds between edges while inputs change
        drive(4'd3, 4'd4, 1'b0);
        step();
        check("lat_first", {bus.cout, bus.sum}, 5'b0_0111);
        drive(4'd9, 4'd8, 1'b1);
        #2;
        check("lat_hold", {bus.cout, bus.sum}, 5'b0_0111);
        step();
        check("lat_second", {bus.cout, bus.sum}, 5'b1_0010);

        // Exhaustive sweep through the scoreboard queue
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            a = i[3:0];
            b = i[7:4];
            c = i[8];
            drive(a, b, c);
            exp_q.push_back(5'(a) + 5'(b) + 5'(c));
            step();
            got = {bus.cout, bus.sum};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sweep_%0d: scoreboard queue empty", i);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("sweep_%0d", i), got, exp);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
